// File: rtl/mole_pkg.sv
// mole_pkg: shared state type, lane count, score width and score LED encoding
package mole_pkg;
    localparam int NUM_LANES = 4;
    localparam int SCORE_W = 32;
    typedef enum logic {PLAY, DONE} state_t;
    function automatic logic [5:0] led_of(input logic [SCORE_W-1:0] s);
        return 6'b000001 << (s % SCORE_W'(6));
    endfunction
endpackage

// File: rtl/mole_lane.sv
// mole_lane: one lane's button edge detect, lamp bit and lit/dark phase counter
module mole_lane #(
    parameter int ON_CYCLES = 20000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int CNT_W = 25
) (
    input logic clk,
    input logic reset,
    input logic btn_n,
    input logic play,
    input logic hold,
    input logic clear,
    output logic lamp,
    output logic hit,
    output logic timeout
);
    logic prev;
    logic press;
    logic relight;
    logic [CNT_W-1:0] cnt;
    assign press = prev & ~btn_n;
    // unscored outside PLAY; lane 0's hit doubles as the restart request while lamps are forced lit
    assign hit = lamp & press;
    assign timeout = play & lamp & ~press & (cnt >= CNT_W'(ON_CYCLES));
    assign relight = play & ~lamp & (cnt >= CNT_W'(OFF_CYCLES));
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
            lamp <= 1'b1;
            cnt <= '0;
        end else begin
            prev <= btn_n;
            if (clear) begin
                lamp <= 1'b0;
                cnt <= '0;
            end else if (hold) begin
                lamp <= 1'b1;
                cnt <= '0;
            end else if ((play & hit) | timeout | relight) begin
                lamp <= ~lamp;
                cnt <= '0;
            end else if (play) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: four-lane whack-a-mole game, lane timing in mole_lane, scoring and PLAY/DONE FSM here
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int ON_CYCLES = 20000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int WIN_SCORE = 12,
    parameter int START_SCORE = 3,
    parameter int COOLDOWN = 1000
) (
    input logic clk,
    input logic reset,
    input logic [NUM_LANES-1:0] btn_n,
    output logic [NUM_LANES-1:0] lamp,
    output logic ingame,
    output logic [SCORE_W-1:0] score,
    output logic [5:0] score_led
);
    localparam int MAX_CYC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam int COOL_W = $clog2(COOLDOWN + 2);
    state_t state;
    state_t state_nx;
    logic [COOL_W-1:0] cool;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] timeout;
    logic play;
    logic hold;
    logic restart;
    logic [2:0] n_hit;
    logic [2:0] n_to;
    logic [SCORE_W+1:0] sum;
    logic [SCORE_W-1:0] score_nx;
    assign play = state == PLAY;
    assign hold = state_nx == DONE;
    assign ingame = play;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mole_lane #(
            .ON_CYCLES(ON_CYCLES),
            .OFF_CYCLES(OFF_CYCLES),
            .CNT_W(CNT_W)
        ) u_lane (
            .clk(clk),
            .reset(reset),
            .btn_n(btn_n[i]),
            .play(play),
            .hold(hold),
            .clear(restart),
            .lamp(lamp[i]),
            .hit(hit[i]),
            .timeout(timeout[i])
        );
    end
    // sign bit flags a negative total (floor at 0); the bit below it flags wrap past all-ones
    always_comb begin
        n_hit = 3'($countones(hit));
        n_to = 3'($countones(timeout));
        sum = {2'b00, score} + (SCORE_W+2)'(n_hit) - (SCORE_W+2)'(n_to);
        score_nx = sum[SCORE_W+1] ? '0 : sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
    always_comb begin
        restart = state == DONE && hit[0] && cool > COOL_W'(COOLDOWN);
        state_nx = play ? (score >= SCORE_W'(WIN_SCORE) ? DONE : PLAY) : (restart ? PLAY : DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLAY;
            cool <= '0;
            score <= '0;
            score_led <= 6'b000001;
        end else begin
            state <= state_nx;
            score_led <= led_of(score);
            score <= play ? score_nx : (restart ? SCORE_W'(START_SCORE) : score);
            cool <= (state == DONE && !restart) ? (cool > COOL_W'(COOLDOWN) ? cool : cool + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed scenarios with hand-computed expectations (ON=8, OFF=10, WIN=12, START=3, COOLDOWN=5)
module tb_mole_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] lamp;
    logic ingame;
    logic [31:0] score;
    logic [5:0] score_led;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mole_scheduler #(
        .ON_CYCLES(8),
        .OFF_CYCLES(10),
        .WIN_SCORE(12),
        .START_SCORE(3),
        .COOLDOWN(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_n(btn_n),
        .lamp(lamp),
        .ingame(ingame),
        .score(score),
        .score_led(score_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        btn_n = ~mask;
        tick(1);
        btn_n = 4'hF;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_n = 4'hF;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_lamp"}, 32'(lamp), 32'hF);
        check({tag, "_score"}, score, 0);
        check({tag, "_led"}, 32'(score_led), 32'b000001);
        check({tag, "_ingame"}, 32'(ingame), 1);
    endtask

    // t counts edges after reset release; a lane hit at edge e relights at e+11, a lamp lit at L times out at L+9
    task automatic play_to_done();
        press(4'b1111);
        check("p_t1_score", score, 4);
        check("p_t1_lamp", 32'(lamp), 32'b0000);
        tick(11);
        press(4'b1011);
        check("p_t13_score", score, 7);
        check("p_t13_lamp", 32'(lamp), 32'b0100);
        tick(5);
        press(4'b0100);
        check("p_t19_score", score, 8);
        tick(5);
        press(4'b1011);
        check("p_t25_score", score, 11);
        tick(11);
        check("p_t36_lamp", 32'(lamp), 32'b1111);
        press(4'b0101);
        check("p_t37_score", score, 13);
        check("p_t37_ingame", 32'(ingame), 1);
        check("p_t37_led", 32'(score_led), 32'b100000);
        tick(1);
        check("done_ingame", 32'(ingame), 0);
        check("done_lamp", 32'(lamp), 32'hF);
        check("done_score", score, 13);
        check("done_led", 32'(score_led), 32'b000010);
    endtask

    initial begin
        do_reset();
        check_reset("rst0");
        tick(9);
        check("idle_lamp", 32'(lamp), 32'b0000);
        check("idle_score", score, 0);
        check("idle_led", 32'(score_led), 32'b000001);

        do_reset();
        check_reset("rst1");
        press(4'b0001);
        tick(1);
        press(4'b1000);
        check("s2_score", score, 2);
        tick(1);
        check("s2_led", 32'(score_led), 32'b000100);
        tick(4);
        press(4'b0010);
        check("hit_to_score", score, 2);
        check("hit_to_lamp", 32'(lamp), 32'b0000);
        tick(1);
        btn_n = 4'b1110;
        tick(3);
        check("hold_score", score, 2);
        check("hold_lamp", 32'(lamp), 32'b0001);
        btn_n = 4'hF;
        tick(1);
        check("release_score", score, 2);
        press(4'b0001);
        check("repress_score", score, 3);
        check("repress_lamp", 32'(lamp), 32'b1000);

        do_reset();
        check_reset("rst_play");
        play_to_done();
        tick(3);
        press(4'b0001);
        check("cool3_ingame", 32'(ingame), 0);
        check("cool3_score", score, 13);
        tick(1);
        press(4'b0010);
        check("lane1_ingame", 32'(ingame), 0);
        press(4'b0001);
        check("restart_ingame", 32'(ingame), 1);
        check("restart_score", score, 3);
        check("restart_lamp", 32'(lamp), 32'b0000);
        tick(1);
        check("restart_led", 32'(score_led), 32'b001000);
        tick(3);
        do_reset();
        check_reset("rst_play2");

        play_to_done();
        tick(2);
        do_reset();
        check_reset("rst_done");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
